vga_glyph_capture: RTL
======================

// Module: vga_glyph_capture
// PURPOSE
//  Read-side counterpart of the glyph drawers: snoops the vga_bus stream and captures a 16x16
//  screen window as a 1-bit glyph bitmap (pixel == MATCH_COLOR -> 1), in font-ROM row format.
//  Armed by a request, captures one full frame window, then drains the 16 rows over a valid/ready
//  port. Sits as a passive tap on any vga_bus stage; used for on-chip self-check of drawn digits.
// PARAMETERS
//  RECT_CHAR_X   504     hcount of window's leftmost pixel
//  RECT_CHAR_Y   376     vcount of window's top line
//  MATCH_COLOR   12'hfff rgb value captured as a '1' bit
// PORTS
//  clk          in   1    system/pixel clock
//  rst          in   1    synchronous, active-high reset
//  capture_req  in   1    1-cycle arm pulse; ignored unless idle
//  bus_in       in   vga_bus  snooped stream (hcount, vcount, hblnk, vblnk, rgb); not modified
//  row_data     out  16   captured row; bit 15 = leftmost pixel (hcount == RECT_CHAR_X)
//  row_idx      out  4    row number of row_data, 0 = top line
//  row_valid    out  1    row_data/row_idx valid
//  row_ready    in   1    consumer accepts when row_valid & row_ready
//  busy         out  1    high in any state except IDLE
//  done         out  1    1-cycle pulse after row 15 accepted
// BEHAVIOUR
//  Reset: state IDLE; row_data=0, row_idx=0, row_valid=0, busy=0, done=0; line shift reg and
//   16x16 row buffer cleared. Reset in any state aborts immediately, nothing is drained.
//  States: IDLE -> WAIT_FRAME -> CAPTURE -> DRAIN -> IDLE.
//  IDLE: capture_req=1 -> WAIT_FRAME next cycle (busy=1). capture_req in other states ignored.
//  WAIT_FRAME: waits for bus_in.hcount==0 && bus_in.vcount==0 -> CAPTURE (same edge). Guarantees
//   a whole frame is sampled; window rows never come from two different frames.
//  CAPTURE: pixel bit = (rgb==MATCH_COLOR) && !hblnk && !vblnk (blanked pixels read 0).
//   Sampled when RECT_CHAR_X <= hcount < RECT_CHAR_X+16 and RECT_CHAR_Y <= vcount < RECT_CHAR_Y+16,
//   shifted MSB-first into a 16-bit line register. On the cycle hcount==RECT_CHAR_X+15 the
//   completed word (including that pixel) is written to buffer[vcount-RECT_CHAR_Y].
//   Write of row 15 -> DRAIN next cycle. Comparisons done at full hcount/vcount width; no wrap.
//  DRAIN: row_idx starts at 0; row_valid=1, row_data=buffer[row_idx] registered, stable while
//   row_valid & !row_ready. On valid&ready: row_idx+1 and new data next cycle (back-to-back rows,
//   1/cycle with ready held high). Accept of row 15 -> row_valid=0, done=1 for one cycle, IDLE.
//  busy deasserts in the same cycle done pulses. A new capture_req on the done cycle is ignored;
//   accepted from the following cycle.
//  Latency: capture complete 1 cycle after window's last pixel; first row_valid the cycle after.
//  No bus_out; stream timing unaffected. Only one frame per request; no buffering of a 2nd frame.
// TESTING
//  1 Reset then idle stream: all outputs 0, busy=0; capture_req during rst ignored.
//  2 Drive rgb=12'hfff only at hcount==504 on lines 376..391, req -> 16 rows each 16'h8000,
//    row_idx 0..15, done pulse once, busy low after.
//  3 Checkerboard (fff where (h^v)&1) in window, ready=1 -> rows alternate 16'h5555/16'hAAAA
//    (row 0 = 16'h5555 for even X,Y), delivered on 16 consecutive cycles.
//  4 Random row_ready stalls -> row_data/row_idx held while stalled, no row lost or repeated;
//    second capture_req mid-DRAIN ignored (exactly 16 rows).
//  5 Request issued mid-frame (vcount=380) -> no rows written until next frame's (0,0);
//    rgb changed between frames -> captured bits match second frame only.
//  6 rst asserted in CAPTURE (row 7) -> outputs reset next cycle, no done; new req captures OK.

Source files
------------

// File: rtl/vga_glyph_capture_if.sv
// Pixel stream bundle shared by the VGA pipeline stages.
// Taps that only observe the stream connect through the snk modport.
interface vga_bus;
   logic [10:0] hcount;
   logic [10:0] vcount;
   logic        hblnk;
   logic        vblnk;
   logic [11:0] rgb;

   modport src (output hcount, vcount, hblnk, vblnk, rgb);
   modport snk (input  hcount, vcount, hblnk, vblnk, rgb);
endinterface

// File: rtl/vga_glyph_capture.sv
// Passive vga_bus tap: captures a 16x16 window of one whole frame as a 1-bit glyph
// (font-ROM row format, bit 15 = leftmost pixel) and drains the rows over valid/ready.
module vga_glyph_capture #(
   parameter int          RECT_CHAR_X = 504,
   parameter int          RECT_CHAR_Y = 376,
   parameter logic [11:0] MATCH_COLOR = 12'hfff
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        capture_req,
   vga_bus.snk         bus_in,
   output logic [15:0] row_data,
   output logic [3:0]  row_idx,
   output logic        row_valid,
   input  logic        row_ready,
   output logic        busy,
   output logic        done
);
   localparam logic [10:0] X_LO = 11'(RECT_CHAR_X);
   localparam logic [10:0] X_HI = 11'(RECT_CHAR_X + 15);
   localparam logic [10:0] Y_LO = 11'(RECT_CHAR_Y);
   localparam logic [10:0] Y_HI = 11'(RECT_CHAR_Y + 15);

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      WAIT_FRAME = 2'd1,
      CAPTURE    = 2'd2,
      DRAIN      = 2'd3
   } state_t;

   state_t      state_reg;
   logic [15:0] line_reg;
   logic [15:0] buffer_reg [16];

   logic        in_x;
   logic        in_y;
   logic        pix_bit;
   logic        row_wr;
   logic [3:0]  wr_row;
   logic [15:0] line_next;

   // Window test at full counter width so no alias of the window ever matches.
   assign in_x      = (bus_in.hcount >= X_LO) && (bus_in.hcount <= X_HI);
   assign in_y      = (bus_in.vcount >= Y_LO) && (bus_in.vcount <= Y_HI);
   assign pix_bit   = (bus_in.rgb == MATCH_COLOR) && !bus_in.hblnk && !bus_in.vblnk;
   assign line_next = {line_reg[14:0], pix_bit};
   assign wr_row    = bus_in.vcount[3:0] - Y_LO[3:0];
   assign row_wr    = (state_reg == CAPTURE) && in_y && (bus_in.hcount == X_HI);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) begin
            buffer_reg[i] <= '0;
         end
      end else if (row_wr) begin
         buffer_reg[wr_row] <= line_next;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         line_reg  <= '0;
         row_data  <= '0;
         row_idx   <= '0;
         row_valid <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state_reg)
            IDLE: begin
               // A request landing on the done cycle is dropped on purpose.
               if (capture_req && !done) begin
                  state_reg <= WAIT_FRAME;
                  busy      <= 1'b1;
               end
            end
            WAIT_FRAME: begin
               if (bus_in.hcount == '0 && bus_in.vcount == '0) begin
                  state_reg <= CAPTURE;
                  line_reg  <= '0;
               end
            end
            CAPTURE: begin
               if (in_x && in_y) begin
                  line_reg <= line_next;
               end
               if (row_wr && wr_row == 4'd15) begin
                  state_reg <= DRAIN;
               end
            end
            DRAIN: begin
               if (!row_valid) begin
                  row_data  <= buffer_reg[row_idx];
                  row_valid <= 1'b1;
               end else if (row_ready) begin
                  if (row_idx == 4'd15) begin
                     row_valid <= 1'b0;
                     row_idx   <= '0;
                     done      <= 1'b1;
                     busy      <= 1'b0;
                     state_reg <= IDLE;
                  end else begin
                     row_idx  <= row_idx + 4'd1;
                     row_data <= buffer_reg[row_idx + 4'd1];
                  end
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end
endmodule
